// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I Funct3 width codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - 2-bit state encoding for the LSU controller
//   - req_bad(): classifies an incoming request as unusable (illegal
//     combination or misaligned), which sends the LSU to its error state
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // True when the request must not reach the bus: conflicting direction,
  // unknown width code, unsigned width on a store, or a misaligned address.
  function automatic logic req_bad(input logic       rd,
                                   input logic       wr,
                                   input logic [2:0] f3,
                                   input logic [1:0] off);
    logic invalid;
    logic misaligned;
    invalid    = (rd & wr) ||
                 (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                 (wr && ((f3 == F3_BU) || (f3 == F3_HU)));
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
                 ((f3 == F3_W) && (off != 2'b00));
    return invalid | misaligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational lane select and sign/zero extension of a bus read word.
// Ports:
//   i_rdata  [31:0] raw word returned by the bus
//   i_off    [1:0]  byte offset of the load address
//   i_funct3 [2:0]  RV32I load width code
//   o_data   [31:0] extended load value
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  // Shift the addressed lane down to bit 0; halfwords only use off[1]
  // because alignment has already been enforced.
  assign w_byte_sh = i_rdata >> {i_off, 3'b000};
  assign w_half_sh = i_rdata >> {i_off[1], 4'b0000};

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      F3_BU:   o_data = {24'd0, w_byte_sh[7:0]};
      F3_H:    o_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      F3_HU:   o_data = {16'd0, w_half_sh[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multicycle data-memory access stage: converts a core load/store into a
// req/ack bus transaction, stalls the core while it is outstanding, and
// returns the aligned, extended load result.
// Parameters:
//   TIMEOUT  BUS-state cycles to wait for bus_ack before erroring (0 = never)
//   CNT_W    timeout counter width, 2**CNT_W > TIMEOUT
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   MemRead, MemWrite          load / store request (held while Stall=1)
//   Funct3, Addr, WriteData    width code, byte address, store data
//   Read_Data                  registered extended load result
//   Stall                      core must hold PC and inputs
//   LsuErr                     one-cycle error pulse
//   bus_req/we/addr/be/wdata   registered bus request outputs
//   bus_ack, bus_rdata         bus completion and read word
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] Read_Data,
  output logic        Stall,
  output logic        LsuErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_read_data;
  logic             r_lsu_err;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_bus_be;
  logic [31:0]      r_bus_wdata;
  logic [1:0]       r_off;
  logic [2:0]       r_f3;

  logic        w_req;
  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_req = MemRead | MemWrite;
  assign w_bad = req_bad(MemRead, MemWrite, Funct3, Addr[1:0]);

  // Stall must rise in the same cycle the request appears, before any
  // register has seen it, so it is decoded from state plus live inputs.
  assign Stall = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUS);

  // Lane placement for stores; loads always enable the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    if (MemWrite) begin
      case (Funct3)
        F3_B: begin
          w_be    = 4'b0001 << Addr[1:0];
          w_wdata = {4{WriteData[7:0]}};
        end
        F3_H: begin
          w_be    = 4'b0011 << Addr[1:0];
          w_wdata = {2{WriteData[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = WriteData;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .i_rdata  (bus_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_lsu_err   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_off       <= '0;
      r_f3        <= '0;
    end else begin
      r_lsu_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_bad) begin
              r_lsu_err <= 1'b1;
              r_state   <= ST_ERR;
            end else begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= MemWrite;
              r_bus_addr  <= {Addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
              r_off       <= Addr[1:0];
              r_f3        <= Funct3;
              r_cnt       <= '0;
              r_state     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // An ack always wins over a timeout landing in the same cycle.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
              r_read_data <= w_ext;
            end
            r_state <= ST_DONE;
          end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
            r_bus_req <= 1'b0;
            r_lsu_err <= 1'b1;
            r_state   <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Read_Data = r_read_data;
  assign LsuErr    = r_lsu_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule
